keypad_mult_ctrl: RTL

- Sequences an operand-entry and multiply transaction for the keypad multiplier.
- Consumes the debounced key strobe and 4-bit key code from the keypad scanner/debounce chain.
- Assembles two decimal operands into binary, launches the multiplier with a start/done handshake, then holds the product for display.
- Sits between the keypad front end and the multiplier datapath/display.

---
 rtl/keypad_mult_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/keypad_mult_ctrl.sv
// keypad_mult_ctrl: reads two decimal operands from keypad key events, runs one
// multiply using a start/done handshake with the multiplier, then holds the product.
// Ports: clk/rst (sync, active-high); key_valid/key_code from the debounced scanner;
//        mult_start/mult_a/mult_b/mult_done/mult_result to the multiplier;
//        disp_value/phase/err to the display. All outputs come from registers.
module keypad_mult_ctrl #(
  parameter int OP_W        = 10,
  parameter int N_DIGITS    = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              mult_done,
  input  logic [2*OP_W-1:0] mult_result,
  output logic              mult_start,
  output logic [OP_W-1:0]   mult_a,
  output logic [OP_W-1:0]   mult_b,
  output logic [2*OP_W-1:0] disp_value,
  output logic [2:0]        phase,
  output logic              err
);

  localparam int DC_W = (N_DIGITS > 1) ? $clog2(N_DIGITS + 1) : 1;
  localparam int TC_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    ENTRY_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              key_valid_q;
  logic [OP_W-1:0]   acc, acc_nxt, op_a, op_a_nxt, op_b, op_b_nxt;
  logic [DC_W-1:0]   dcnt, dcnt_nxt;
  logic [TC_W-1:0]   tcnt, tcnt_nxt;
  logic [2*OP_W-1:0] result, result_nxt, disp_nxt;
  logic              err_nxt, start_nxt;

  // A held key yields exactly one event, on its rising edge.
  logic kev, is_digit, is_enter, is_clear;
  assign kev      = key_valid & ~key_valid_q;
  assign is_digit = (key_code <= 4'd9);
  assign is_enter = (key_code == 4'hA);
  assign is_clear = (key_code == 4'hC);

  // Decimal shift-in; cannot overflow because digit count is capped at N_DIGITS.
  logic [OP_W-1:0] acc_mac;
  assign acc_mac = acc * OP_W'(10) + {{(OP_W-4){1'b0}}, key_code};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ENTRY_A;
    else     state <= state_nxt;
  end

  // Next-state and datapath updates
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    dcnt_nxt   = dcnt;
    op_a_nxt   = op_a;
    op_b_nxt   = op_b;
    result_nxt = result;
    tcnt_nxt   = tcnt;
    err_nxt    = err;
    case (state)
      ENTRY_A, ENTRY_B: begin
        if (kev) begin
          if (is_digit) begin
            if (dcnt < DC_W'(N_DIGITS)) begin
              acc_nxt  = acc_mac;
              dcnt_nxt = dcnt + DC_W'(1);
            end
          end else if (is_enter) begin
            if (dcnt != '0) begin
              if (state == ENTRY_A) begin
                op_a_nxt  = acc;
                acc_nxt   = '0;
                dcnt_nxt  = '0;
                state_nxt = ENTRY_B;
              end else begin
                op_b_nxt  = acc;
                state_nxt = START;
              end
            end
          end else if (is_clear) begin
            acc_nxt  = '0;
            dcnt_nxt = '0;
            // Clearing during B abandons the whole entry, including A.
            if (state == ENTRY_B) begin
              op_a_nxt  = '0;
              state_nxt = ENTRY_A;
            end
          end
        end
      end
      START: begin
        tcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mult_done) begin
          result_nxt = mult_result;
          state_nxt  = SHOW;
        end else if (tcnt == TC_W'(TIMEOUT_CYC - 1)) begin
          err_nxt    = 1'b1;
          result_nxt = '0;
          state_nxt  = SHOW;
        end else begin
          tcnt_nxt = tcnt + TC_W'(1);
        end
      end
      SHOW: begin
        // The key that leaves SHOW is consumed; it is not entered as a digit.
        if (kev && (is_digit || is_enter || is_clear)) begin
          acc_nxt    = '0;
          dcnt_nxt   = '0;
          op_a_nxt   = '0;
          op_b_nxt   = '0;
          result_nxt = '0;
          err_nxt    = 1'b0;
          state_nxt  = ENTRY_A;
        end
      end
      default: state_nxt = ENTRY_A;
    endcase
  end

  // Output values for the coming cycle. They are decoded from the next state,
  // so the registered outputs and phase stay aligned.
  always_comb begin
    start_nxt = (state_nxt == START);
    disp_nxt  = '0;
    case (state_nxt)
      ENTRY_A, ENTRY_B: disp_nxt = {{OP_W{1'b0}}, acc_nxt};
      START, WAIT:      disp_nxt = {{OP_W{1'b0}}, op_b_nxt};
      SHOW:             disp_nxt = result_nxt;
      default:          disp_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid_q <= 1'b0;
      acc         <= '0;
      dcnt        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      tcnt        <= '0;
      err         <= 1'b0;
      mult_start  <= 1'b0;
      disp_value  <= '0;
    end else begin
      key_valid_q <= key_valid;
      acc         <= acc_nxt;
      dcnt        <= dcnt_nxt;
      op_a        <= op_a_nxt;
      op_b        <= op_b_nxt;
      result      <= result_nxt;
      tcnt        <= tcnt_nxt;
      err         <= err_nxt;
      mult_start  <= start_nxt;
      disp_value  <= disp_nxt;
    end
  end

  // Operand registers drive the multiplier directly, so they are valid in START.
  assign mult_a = op_a;
  assign mult_b = op_b;
  assign phase  = state;

endmodule
